// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode-to-execute stage: opcodes, trap causes,
// control-bundle layout and the bubble value, plus the occupancy encoding.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;

  // Control bundle, MSB first; 18 bits total.
  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic [1:0] memToReg;
    logic [1:0] pcBranch;
    logic [1:0] srcASel;
    logic [1:0] srcBSel;
    logic [3:0] aluOp;
    logic [2:0] strCtrl;
    logic       jalrCtrl;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    regWrite: 1'b0, memWrite: 1'b0, memToReg: 2'b00, pcBranch: 2'b00,
    srcASel: 2'b01, srcBSel: 2'b11, aluOp: 4'b0000, strCtrl: 3'b000,
    jalrCtrl: 1'b1
  };

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/id_ex_stage_instr_legal_chk.sv
// Combinational RV32I legality and environment-call check producing the
// trap status {exception, cause, mtval} for one instruction.
module instr_legal_chk
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            exception_o,
  output logic [4:0]      cause_o,
  output logic [XLEN-1:0] mtval_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_ALUREG: illegal = !(funct7 == 7'h00 || funct7 == 7'h20) ||
                           (funct7 == 7'h20 && !(funct3 == 3'b000 || funct3 == 3'b101));
      OP_ALUIMM: begin
        if (funct3 == 3'b001)      illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101) illegal = !(funct7 == 7'h00 || funct7 == 7'h20);
      end
      OP_BRANCH: illegal = (funct3 == 3'b010 || funct3 == 3'b011);
      OP_LOAD:   illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      OP_STORE:  illegal = (funct3 > 3'b010);
      OP_JALR:   illegal = (funct3 != 3'b000);
      OP_JAL, OP_AUIPC, OP_LUI: illegal = 1'b0;
      // No CSR support, so only the two exact environment encodings survive.
      OP_SYSTEM: illegal = !(instr_i == INSTR_ECALL || instr_i == INSTR_EBREAK);
      default:   illegal = 1'b1;
    endcase
  end

  always_comb begin
    exception_o = 1'b0;
    cause_o     = '0;
    mtval_o     = '0;
    if (instr_i == INSTR_ECALL) begin
      exception_o = 1'b1;
      cause_o     = CAUSE_ECALL_M;
    end else if (instr_i == INSTR_EBREAK) begin
      exception_o = 1'b1;
      cause_o     = CAUSE_BREAKPOINT;
      mtval_o     = pc_i;
    end else if (illegal) begin
      exception_o = 1'b1;
      cause_o     = CAUSE_ILLEGAL;
      mtval_o     = XLEN'(instr_i);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage with valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and per-entry trap status; halts intake after a trap.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int                 XLEN     = 32,
  parameter int                 CTRL_W   = 18,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CTRL_BUBBLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_r1,
  input  logic [XLEN-1:0]   in_r2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_r1,
  output logic [XLEN-1:0]   out_r2,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic              out_exception,
  output logic [4:0]        out_cause,
  output logic [XLEN-1:0]   out_mtval
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   r1;
    logic [XLEN-1:0]   r2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   mtval;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        cause;
    logic              exc;
  } entry_t;

  occ_e   occ_q, occ_d;
  logic   halted_q, halted_d;
  entry_t main_q, main_d, skid_q, skid_d, newEntry;
  logic   chkExc;
  logic [4:0] chkCause;
  logic [XLEN-1:0] chkMtval;
  logic   accept, consume;

  instr_legal_chk #(.XLEN(XLEN)) u_legal_chk (
    .instr_i     (in_instr),
    .pc_i        (in_pc),
    .exception_o (chkExc),
    .cause_o     (chkCause),
    .mtval_o     (chkMtval)
  );

  assign in_ready  = (occ_q != OCC_TWO) && !halted_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // A trapping entry keeps its payload but must not perform any side effect.
  always_comb begin
    newEntry.pc    = in_pc;
    newEntry.r1    = in_r1;
    newEntry.r2    = in_r2;
    newEntry.imm   = in_imm;
    newEntry.mtval = chkMtval;
    newEntry.ctrl  = chkExc ? CTRL_NOP : in_ctrl;
    newEntry.rd    = in_instr[11:7];
    newEntry.rs1   = in_instr[19:15];
    newEntry.rs2   = in_instr[24:20];
    newEntry.cause = chkCause;
    newEntry.exc   = chkExc;
  end

  always_comb begin
    occ_d    = occ_q;
    halted_d = halted_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      occ_d    = OCC_EMPTY;
      halted_d = 1'b0;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d = newEntry;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && consume) begin
            main_d = newEntry;
          end else if (accept) begin
            skid_d = newEntry;
            occ_d  = OCC_TWO;
          end else if (consume) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (consume) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
      if (accept && newEntry.exc) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= OCC_EMPTY;
      halted_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      occ_q    <= occ_d;
      halted_q <= halted_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign out_pc        = main_q.pc;
  assign out_r1        = main_q.r1;
  assign out_r2        = main_q.r2;
  assign out_imm       = main_q.imm;
  assign out_ctrl      = out_valid ? main_q.ctrl : CTRL_NOP;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_exception = out_valid && main_q.exc;
  assign out_cause     = main_q.cause;
  assign out_mtval     = main_q.mtval;

endmodule
